// File: rtl/thermal_covert_tx_if.sv
// Payload handshake between the message source (master) and the transmitter (slave).
interface thermal_covert_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/thermal_covert_tx.sv
// Thermal covert-channel transmitter: frames a payload as preamble + MSB-first data + guard
// and drives every heater bank with the OOK- or Manchester-coded line level.
module thermal_covert_tx #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned HEATER_BANKS  = 8,
    parameter int unsigned PREAMBLE_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [CNT_W-1:0]        bit_period,
    thermal_covert_tx_if.slave      tx_if,
    output logic [HEATER_BANKS-1:0] heater_en,
    output logic [CNT_W-1:0]        counter_output,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              leds
);

    localparam int unsigned IdxMax = (DATA_W > PREAMBLE_BITS) ? DATA_W : PREAMBLE_BITS;
    localparam int unsigned IdxW   = ($clog2(IdxMax) > 4) ? $clog2(IdxMax) : 4;
    localparam logic [IdxW-1:0] PreLast  = IdxW'(PREAMBLE_BITS - 1);
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPreamble = 2'd1,
        StData     = 2'd2,
        StGuard    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic [CNT_W-1:0]        period_q, period_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [HEATER_BANKS-1:0] heater_q, heater_d;
    logic                    done_q, done_d;

    logic              accept;
    logic [CNT_W-1:0]  p_eff;
    logic [DATA_W-1:0] data_sh;
    logic              sym;
    logic              level;
    logic              idx_last;
    logic              sym_end;
    state_e            next_st;

    assign tx_if.tx_ready = (state_q == StIdle) & enable & reset;
    assign accept         = tx_if.tx_valid & tx_if.tx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        period_d = period_q;
        data_d   = data_q;
        heater_d = '0;
        done_d   = 1'b0;
        sym      = 1'b0;
        idx_last = 1'b0;
        next_st  = StIdle;
        data_sh  = data_q << idx_q;

        // Manchester needs two half-symbols, so its period floor is 2.
        p_eff = bit_period;
        if (p_eff == '0) begin
            p_eff = CNT_W'(1);
        end
        if (mode && (p_eff < CNT_W'(2))) begin
            p_eff = CNT_W'(2);
        end

        unique case (state_q)
            StIdle: begin
                next_st = StIdle;
            end
            StPreamble: begin
                sym      = ~idx_q[0];
                idx_last = (idx_q == PreLast);
                next_st  = StData;
            end
            StData: begin
                sym      = data_sh[DATA_W-1];
                idx_last = (idx_q == DataLast);
                next_st  = StGuard;
            end
            StGuard: begin
                idx_last = 1'b1;
                next_st  = StIdle;
            end
        endcase

        level   = ((state_q == StPreamble) || (state_q == StData)) &
                  ((mode_q && (cnt_q >= (period_q >> 1))) ? ~sym : sym);
        sym_end = (cnt_q == period_q - CNT_W'(1));

        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == StIdle) begin
            if (accept) begin
                state_d  = StPreamble;
                cnt_d    = '0;
                idx_d    = '0;
                mode_d   = mode;
                period_d = p_eff;
                data_d   = tx_if.tx_data;
            end
        end else begin
            heater_d = {HEATER_BANKS{level}};
            if (sym_end) begin
                cnt_d = '0;
                if (idx_last) begin
                    idx_d   = '0;
                    state_d = next_st;
                    done_d  = (state_q == StGuard);
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            mode_q   <= 1'b0;
            period_q <= '0;
            data_q   <= '0;
            heater_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            data_q   <= data_d;
            heater_q <= heater_d;
            done_q   <= done_d;
        end
    end

    assign heater_en      = heater_q;
    assign counter_output = cnt_q;
    assign done           = done_q;
    assign busy           = (state_q != StIdle);
    assign leds           = {busy, mode_q, state_q, idx_q[3:0]};

endmodule
